// File: rtl/merge_tiles.sv
// merge_tiles: reassembles a stream of FILTER_SIZE x FILTER_SIZE tiles
// into one registered SIZE x SIZE image with a valid/ready handoff.
module merge_tiles #(
    parameter int SIZE        = 9,
    parameter int FILTER_SIZE = 3,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tile_valid,
    output logic              tile_ready,
    input  logic [DATA_W-1:0] tile_data [0:FILTER_SIZE-1][0:FILTER_SIZE-1],
    input  logic              tile_last,
    output logic [(((SIZE/FILTER_SIZE)*(SIZE/FILTER_SIZE)) > 1 ?
                   $clog2((SIZE/FILTER_SIZE)*(SIZE/FILTER_SIZE)) : 1)-1:0]
                              tile_idx,
    output logic              img_valid,
    input  logic              img_ready,
    output logic [DATA_W-1:0] img_data [0:SIZE-1][0:SIZE-1],
    output logic              err
);

    localparam int T  = SIZE / FILTER_SIZE;
    localparam int NT = T * T;
    localparam int CW = (NT > 1) ? $clog2(NT) : 1;
    localparam logic [CW-1:0] LAST = CW'(NT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_idx;
    logic              r_err;
    logic [DATA_W-1:0] r_img [0:SIZE-1][0:SIZE-1];

    logic              w_acc;
    logic              w_is_last;
    logic              w_hand;
    int                w_tr;
    int                w_tc;

    assign w_acc     = tile_valid && (r_state == FILL);
    assign w_is_last = (r_idx == LAST);
    assign w_hand    = img_ready && (r_state == FULL);
    assign w_tr      = int'(r_idx) / T;
    assign w_tc      = int'(r_idx) % T;

    assign tile_idx  = r_idx;
    assign err       = r_err;
    assign img_data  = r_img;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: fill until the last tile, hold until handoff
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: w_next = FILL;
            FILL: if (w_acc && w_is_last) w_next = FULL;
            FULL: if (w_hand) w_next = FILL;
            default: w_next = IDLE;
        endcase
    end

    // Output logic: handshake flags follow the state directly
    always_comb begin
        tile_ready = 1'b0;
        img_valid  = 1'b0;
        unique case (r_state)
            FILL: tile_ready = 1'b1;
            FULL: img_valid  = 1'b1;
            default: begin
                tile_ready = 1'b0;
                img_valid  = 1'b0;
            end
        endcase
    end

    // Tile counter; wraps to zero on the final tile of the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_acc) begin
            r_idx <= w_is_last ? '0 : r_idx + 1'b1;
        end
    end

    // Sticky framing error: tile_last must coincide with the count end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_acc && (tile_last != w_is_last)) begin
            r_err <= 1'b1;
        end
    end

    // Pixel store: only the block covered by the current tile is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    r_img[r][c] <= '0;
                end
            end
        end else if (w_acc) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    if ((r / FILTER_SIZE) == w_tr &&
                        (c / FILTER_SIZE) == w_tc) begin
                        r_img[r][c] <=
                            tile_data[r % FILTER_SIZE][c % FILTER_SIZE];
                    end
                end
            end
        end
    end

endmodule
